mem_arb: RTL and testbench

Two-requester arbiter sharing one single-ported, synchronous-read memory between the instruction-fetch path and the load/store path of the core. Grants at most one request per cycle, drives the shared memory port combinationally from the winner, and routes the one-cycle-latency read data back to the granted requester. Data accesses have priority; a streak counter bounds instruction-fetch starvation.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_arb.sv | 91 +++++++++
 tb/tb_mem_arb.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared widths and response-owner encodings for mem_arb.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

   localparam int WORD_W = 32;
   localparam int MASK_W = 4;

   // One-hot {D,I} owner of the access issued in the previous cycle
   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_I    = 2'b01;
   localparam logic [1:0] OWN_D    = 2'b10;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb
// Description : Fetch / load-store arbiter for a single-ported synchronous memory,
//               data-priority with a bounded fetch starvation streak.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb
   import mem_pkg::*;
#(
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [WORD_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [WORD_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic [WORD_W-1:0] d_addr,
   input  logic [MASK_W-1:0] d_wmask,
   input  logic [WORD_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [WORD_W-1:0] d_rdata,
   output logic [WORD_W-1:0] m_addr,
   output logic [MASK_W-1:0] m_wmask,
   output logic [WORD_W-1:0] m_wdata,
   input  logic [WORD_W-1:0] m_rdata
);

   localparam logic [3:0] c_max_streak = 4'(MAX_D_STREAK);

   logic [3:0] r_d_streak;
   logic [1:0] r_owner;
   logic       w_d_win;
   logic       w_i_gnt;
   logic       w_d_gnt;

   // Data wins unless it has already starved a pending fetch for the full streak
   always_comb begin
      w_d_win = d_req && (!i_req || (r_d_streak != c_max_streak));
      w_d_gnt = w_d_win && !reset;
      w_i_gnt = i_req && !w_d_win && !reset;
   end

   always_comb begin
      m_addr  = d_addr;
      m_wmask = '0;
      m_wdata = '0;
      if (w_d_gnt) begin
         m_wmask = d_wmask;
         m_wdata = d_wdata;
      end else if (w_i_gnt) begin
         m_addr  = i_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_d_streak <= 4'd0;
      end else if (!i_req || w_i_gnt) begin
         r_d_streak <= 4'd0;
      end else if (w_d_gnt && (r_d_streak != c_max_streak)) begin
         r_d_streak <= r_d_streak + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner <= OWN_NONE;
      end else if (w_d_gnt) begin
         r_owner <= OWN_D;
      end else if (w_i_gnt) begin
         r_owner <= OWN_I;
      end else begin
         r_owner <= OWN_NONE;
      end
   end

   assign i_gnt    = w_i_gnt;
   assign d_gnt    = w_d_gnt;
   // Masking with reset drops a response whose grant was followed by reset
   assign i_rvalid = r_owner[0] && !reset;
   assign d_rvalid = r_owner[1] && !reset;
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

endmodule : mem_arb
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arb
// Description : Scoreboard bench for mem_arb with a read-first synchronous memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arb;

   localparam int MAX = 4;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [31:0] d_addr;
   logic [3:0]  d_wmask;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic [31:0] m_addr;
   logic [3:0]  m_wmask;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   mem_arb #(.MAX_D_STREAK(MAX)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_wmask(m_wmask), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: registered read of the old word, then byte-masked write
   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   always @(posedge clk) begin
      m_rdata <= mem[m_addr[9:2]];
      for (int b = 0; b < 4; b++)
         if (m_wmask[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
   end

   typedef struct packed {
      int          due;
      logic        isd;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   int   m_streak = 0;

   // Response monitor: every cycle compares rvalid/rdata with the scoreboard head
   always @(negedge clk) begin
      logic ev_i, ev_d;
      ev_i = 1'b0;
      ev_d = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         ev_i = !q[0].isd;
         ev_d = q[0].isd;
      end
      checks++;
      if (i_rvalid !== ev_i || d_rvalid !== ev_d) begin
         errors++;
         $display("FAIL rvalid cyc=%0d got i=%b d=%b exp i=%b d=%b", cyc, i_rvalid, d_rvalid, ev_i, ev_d);
      end
      if (ev_i || ev_d) begin
         checks++;
         if ((ev_i ? i_rdata : d_rdata) !== q[0].data) begin
            errors++;
            $display("FAIL rdata cyc=%0d port=%s got %h exp %h", cyc, ev_d ? "D" : "I",
                     ev_d ? d_rdata : i_rdata, q[0].data);
         end
         void'(q.pop_front());
      end
   end

   // Drives one cycle, returns model-expected and observed grant info
   task automatic drive_cycle(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic [31:0] da, input logic [3:0] wm, input logic [31:0] wd,
                              output logic egi, output logic egd, output logic ogi,
                              output logic ogd, output logic [3:0] owm);
      i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wmask = wm; d_wdata = wd;
      @(negedge clk);
      egd = dr && (!ir || m_streak != MAX) && !reset;
      egi = ir && !(dr && (!ir || m_streak != MAX)) && !reset;
      ogi = i_gnt; ogd = d_gnt; owm = m_wmask;
      if (egi) q.push_back('{cyc + 1, 1'b0, ref_mem[ia[9:2]]});
      if (egd) begin
         q.push_back('{cyc + 1, 1'b1, ref_mem[da[9:2]]});
         for (int b = 0; b < 4; b++)
            if (wm[b]) ref_mem[da[9:2]][8*b +: 8] = wd[8*b +: 8];
      end
      if (reset || !ir || egi) m_streak = 0;
      else if (egd && m_streak != MAX) m_streak++;
      @(posedge clk); #1;
   endtask

   logic       egi, egd, ogi, ogd;
   logic [3:0] owm;

   task automatic idle_cycle();
      drive_cycle(0, 32'h0, 0, 32'h0, 4'h0, 32'h0, egi, egd, ogi, ogd, owm);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         drive_cycle(1, 32'h20, 1, 32'h24, 4'hF, 32'hDEADBEEF, egi, egd, ogi, ogd, owm);
         checks++;
         if (ogi !== 1'b0 || ogd !== 1'b0 || owm !== 4'h0) begin
            errors++;
            $display("FAIL reset_gnt got i=%b d=%b wm=%h exp 0 0 0", ogi, ogd, owm);
         end
      end
      reset = 1'b0;
      idle_cycle();
   endtask

   task automatic test_fetch();
      drive_cycle(1, 32'h10, 0, 32'h0, 4'h0, 32'h0, egi, egd, ogi, ogd, owm);
      checks++;
      if (ogi !== 1'b1 || ogd !== 1'b0 || owm !== 4'h0) begin
         errors++;
         $display("FAIL fetch_gnt got i=%b d=%b wm=%h exp 1 0 0", ogi, ogd, owm);
      end
      idle_cycle();
   endtask

   task automatic test_store_load();
      drive_cycle(0, 32'h0, 1, 32'h40, 4'b0101, 32'hAABBCCDD, egi, egd, ogi, ogd, owm);
      checks++;
      if (ogd !== 1'b1 || owm !== 4'b0101) begin
         errors++;
         $display("FAIL store_gnt got d=%b wm=%b exp 1 0101", ogd, owm);
      end
      drive_cycle(0, 32'h0, 1, 32'h40, 4'h0, 32'h0, egi, egd, ogi, ogd, owm);
      checks++;
      if (ogd !== 1'b1 || owm !== 4'h0) begin
         errors++;
         $display("FAIL load_gnt got d=%b wm=%b exp 1 0000", ogd, owm);
      end
      idle_cycle();
   endtask

   task automatic test_contention();
      logic exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      for (int k = 0; k < 10; k++) begin
         drive_cycle(1, 32'(k * 4), 1, 32'(32'h80 + k * 4), 4'h0, 32'h0, egi, egd, ogi, ogd, owm);
         checks++;
         if (ogd !== exp_d[k] || ogi !== !exp_d[k]) begin
            errors++;
            $display("FAIL contention[%0d] got i=%b d=%b exp i=%b d=%b", k, ogi, ogd, !exp_d[k], exp_d[k]);
         end
      end
      idle_cycle();
   endtask

   task automatic test_streak_clear();
      logic exp_d [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
      logic ir    [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
      for (int k = 0; k < 9; k++) begin
         drive_cycle(ir[k], 32'h8, 1, 32'(32'h100 + k * 4), 4'(k % 3 == 0 ? 4'h3 : 4'h0),
                     32'(32'h5A5A0000 + k), egi, egd, ogi, ogd, owm);
         checks++;
         if (ogd !== exp_d[k] || ogi !== (ir[k] && !exp_d[k])) begin
            errors++;
            $display("FAIL streak_clear[%0d] got i=%b d=%b exp d=%b", k, ogi, ogd, exp_d[k]);
         end
      end
      idle_cycle();
   endtask

   task automatic test_reset_mid();
      logic exp_d [5] = '{1, 1, 1, 1, 0};
      for (int k = 0; k < 3; k++)
         drive_cycle(1, 32'h0, 1, 32'h44, 4'h0, 32'h0, egi, egd, ogi, ogd, owm);
      reset = 1'b1;
      void'(q.pop_back());
      drive_cycle(1, 32'h0, 1, 32'h48, 4'hF, 32'h12345678, egi, egd, ogi, ogd, owm);
      checks++;
      if (ogd !== 1'b0 || ogi !== 1'b0 || owm !== 4'h0) begin
         errors++;
         $display("FAIL reset_mid_gnt got i=%b d=%b wm=%h exp 0 0 0", ogi, ogd, owm);
      end
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_cycle(1, 32'h4, 1, 32'h4C, 4'h0, 32'h0, egi, egd, ogi, ogd, owm);
         checks++;
         if (ogd !== exp_d[k] || ogi !== !exp_d[k]) begin
            errors++;
            $display("FAIL reset_streak[%0d] got i=%b d=%b exp d=%b", k, ogi, ogd, exp_d[k]);
         end
      end
      idle_cycle();
   endtask

   task automatic test_idle();
      int diffs = 0;
      for (int k = 0; k < 5; k++) begin
         drive_cycle(0, 32'h40, 0, 32'h40, 4'hF, 32'hFFFFFFFF, egi, egd, ogi, ogd, owm);
         checks++;
         if (ogi !== 1'b0 || ogd !== 1'b0 || owm !== 4'h0) begin
            errors++;
            $display("FAIL idle[%0d] got i=%b d=%b wm=%h exp 0 0 0", k, ogi, ogd, owm);
         end
      end
      for (int w = 0; w < 256; w++) if (mem[w] !== ref_mem[w]) diffs++;
      checks++;
      if (diffs != 0) begin
         errors++;
         $display("FAIL mem_contents got %0d differing words exp 0", diffs);
      end
   endtask

   initial begin
      for (int w = 0; w < 256; w++) begin
         mem[w]     = 32'(w * 32'h01010101) ^ 32'hC0DE0000;
         ref_mem[w] = 32'(w * 32'h01010101) ^ 32'hC0DE0000;
      end
      mem[4]      = 32'h00000013;  ref_mem[4]  = 32'h00000013;
      mem[16]     = 32'h11223344;  ref_mem[16] = 32'h11223344;
      reset = 1'b1;
      i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_wmask = 0; d_wdata = 0;
      @(posedge clk); #1;
      test_reset();
      test_fetch();
      test_store_load();
      test_contention();
      test_streak_clear();
      test_reset_mid();
      test_idle();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d outstanding responses exp 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mem_arb
`default_nettype wire
